// File: rtl/zx_video_pkg.sv
// Shared ZX raster constants and per-model lookup helpers for video_timing.
package zx_video_pkg;

    typedef enum logic {
        MODEL_48K  = 1'b0,
        MODEL_128K = 1'b1
    } model_t;

    // Raster geometry in pixel-enable units (two pixels per T-state).
    localparam logic [8:0] LINE_48K   = 9'd448;
    localparam logic [8:0] LINE_128K  = 9'd456;
    localparam logic [8:0] FRAME_48K  = 9'd312;
    localparam logic [8:0] FRAME_128K = 9'd311;

    // Interrupt start column on the interrupt line.
    localparam logic [8:0] INT_H_48K  = 9'd0;
    localparam logic [8:0] INT_H_128K = 9'd4;
    localparam logic [8:0] INT_LINE   = 9'd248;

    // Bitmap area and blanking limits (end values are exclusive).
    localparam logic [8:0] DISP_H_END    = 9'd256;
    localparam logic [8:0] DISP_V_END    = 9'd192;
    localparam logic [8:0] BLANK_H_START = 9'd320;
    localparam logic [8:0] BLANK_H_END   = 9'd416;
    localparam logic [8:0] BLANK_V_START = 9'd248;
    localparam logic [8:0] BLANK_V_END   = 9'd256;

    // Contention window: 12 of every 16 pixels, phase-shifted for the 128K.
    localparam logic [3:0] CONT_OFS_48K  = 4'd0;
    localparam logic [3:0] CONT_OFS_128K = 4'd2;
    localparam logic [3:0] CONT_LIMIT    = 4'd12;

    function automatic logic [8:0] line_last(input model_t m);
        return (m == MODEL_128K) ? (LINE_128K - 9'd1) : (LINE_48K - 9'd1);
    endfunction

    function automatic logic [8:0] frame_last(input model_t m);
        return (m == MODEL_128K) ? (FRAME_128K - 9'd1) : (FRAME_48K - 9'd1);
    endfunction

    function automatic logic [8:0] int_hpos(input model_t m);
        return (m == MODEL_128K) ? INT_H_128K : INT_H_48K;
    endfunction

    function automatic logic [3:0] cont_offset(input model_t m);
        return (m == MODEL_128K) ? CONT_OFS_128K : CONT_OFS_48K;
    endfunction

endpackage

// File: rtl/video_timing.sv
// ZX raster timing generator driven by the 7 MHz pixel enable.
// Produces h/v counters, sync, blanking, bitmap window, frame interrupt
// and, when CONTENTION_EN is defined, the CPU contention request.
// Every output is registered in the same cycle as the counters, so the
// decoded flags always describe the hcount/vcount presented alongside them.
// The machine model is latched only at the frame wrap.
module video_timing
    import zx_video_pkg::*;
#(
    parameter int HS_START = 344,
    parameter int HS_LEN   = 32,
    parameter int VS_START = 248,
    parameter int VS_LEN   = 4,
    parameter int INT_LEN  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       model,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       display,
    output logic       irq,
    output logic       contend
);

    localparam logic [9:0] HS_LO = 10'(HS_START);
    localparam logic [9:0] HS_HI = 10'(HS_START + HS_LEN);
    localparam logic [9:0] VS_LO = 10'(VS_START);
    localparam logic [9:0] VS_HI = 10'(VS_START + VS_LEN);
    localparam logic [9:0] IRQ_W = 10'(INT_LEN);

    model_t     model_q;
    model_t     model_n;
    logic [8:0] hcount_n;
    logic [8:0] vcount_n;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic       display_n;
    logic       irq_n;
    logic       contend_n;
    logic [9:0] h_ext;
    logic [9:0] v_ext;
    logic [9:0] irq_lo;

    // Next raster position; the model latch only moves on the frame wrap.
    always_comb begin
        hcount_n = hcount + 9'd1;
        vcount_n = vcount;
        model_n  = model_q;
        if (hcount == line_last(model_q)) begin
            hcount_n = 9'd0;
            if (vcount == frame_last(model_q)) begin
                vcount_n = 9'd0;
                model_n  = model_t'(model);
            end else begin
                vcount_n = vcount + 9'd1;
            end
        end
    end

    // Decode flags from the next position so they register alongside it.
    always_comb begin
        h_ext     = {1'b0, hcount_n};
        v_ext     = {1'b0, vcount_n};
        irq_lo    = {1'b0, int_hpos(model_n)};
        hsync_n   = (h_ext >= HS_LO) && (h_ext < HS_HI);
        vsync_n   = (v_ext >= VS_LO) && (v_ext < VS_HI);
        blank_n   = ((hcount_n >= BLANK_H_START) && (hcount_n < BLANK_H_END)) ||
                    ((vcount_n >= BLANK_V_START) && (vcount_n < BLANK_V_END));
        display_n = (hcount_n < DISP_H_END) && (vcount_n < DISP_V_END);
        irq_n     = (vcount_n == INT_LINE) && (h_ext >= irq_lo) &&
                    (h_ext < (irq_lo + IRQ_W));
    end

`ifdef CONTENTION_EN
    logic [3:0] cont_phase;

    // Contention: the first 12 pixels of each 16-pixel fetch group inside the bitmap.
    always_comb begin
        cont_phase = hcount_n[3:0] + cont_offset(model_n);
        contend_n  = display_n && (cont_phase < CONT_LIMIT);
    end
`else
    assign contend_n = 1'b0;
`endif

    // Register counters, model latch and all flags together; ce=0 holds them.
    always_ff @(posedge clock) begin
        if (reset) begin
            hcount  <= 9'd0;
            vcount  <= 9'd0;
            model_q <= MODEL_48K;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            blank   <= 1'b0;
            display <= 1'b0;
            irq     <= 1'b0;
            contend <= 1'b0;
        end else if (ce) begin
            hcount  <= hcount_n;
            vcount  <= vcount_n;
            model_q <= model_n;
            hsync   <= hsync_n;
            vsync   <= vsync_n;
            blank   <= blank_n;
            display <= display_n;
            irq     <= irq_n;
            contend <= contend_n;
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: reset, full 48K frame with a mid-frame
// model change, following 128K frame, mid-frame reset and model latch reset.
// Build with +define+CONTENTION_EN to check the contention output as well.
module tb_video_timing;

`ifdef CONTENTION_EN
    localparam bit CON_ON = 1'b1;
`else
    localparam bit CON_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic       model;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       display;
    logic       irq;
    logic       contend;

    int checks = 0;
    int errors = 0;

    video_timing dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .model   (model),
        .hcount  (hcount),
        .vcount  (vcount),
        .hsync   (hsync),
        .vsync   (vsync),
        .blank   (blank),
        .display (display),
        .irq     (irq),
        .contend (contend)
    );

    // Clock: 10 ns period.
    always #5 clock = ~clock;

    // One clock with the given ce; outputs sampled 1 ns after the edge.
    task automatic tick(input logic c);
        ce = c;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " hcount"},  32'(hcount),  32'd0);
        check({tag, " vcount"},  32'(vcount),  32'd0);
        check({tag, " hsync"},   32'(hsync),   32'd0);
        check({tag, " vsync"},   32'(vsync),   32'd0);
        check({tag, " blank"},   32'(blank),   32'd0);
        check({tag, " display"}, 32'(display), 32'd0);
        check({tag, " irq"},     32'(irq),     32'd0);
        check({tag, " contend"}, 32'(contend), 32'd0);
    endtask

    // Walk one whole frame starting from (0,0) with ce=1, checking every
    // position against the raster formulas, then summarising measured
    // line lengths, sync widths and the interrupt window.
    task automatic walk_frame(input string name, input int line_len, input int frame_len,
                              input int int_h, input int con_off, input int toggle_v);
        int    total = line_len * frame_len;
        int    h;
        int    v;
        int    pos_err = 0, hs_err = 0, vs_err = 0, bl_err = 0;
        int    dp_err = 0, irq_err = 0, con_err = 0, hold_err = 0;
        int    since_h0 = 0, h0_seen = 0, line_bad = 0;
        int    hs_w = 0, hs_pulses = 0, hs_wmin = 1000, hs_wmax = 0;
        int    vs_lines = 0;
        int    irq_cnt = 0, irq_rise_h = -1, irq_rise_v = -1;
        int    con_v0 = 0, con_v200 = 0;
        bit    exp_hs, exp_vs, exp_bl, exp_dp, exp_irq, exp_con, bad;
        logic [23:0] snap;
        string first_bad = "none";

        for (int n = 1; n <= total; n++) begin
            tick(1'b1);
            h = n % line_len;
            v = (n / line_len) % frame_len;

            exp_hs  = (h >= 344) && (h < 376);
            exp_vs  = (v >= 248) && (v < 252);
            exp_bl  = ((h >= 320) && (h < 416)) || ((v >= 248) && (v < 256));
            exp_dp  = (h < 256) && (v < 192);
            exp_irq = (v == 248) && (h >= int_h) && (h < int_h + 64);
            exp_con = CON_ON && exp_dp && (((h + con_off) % 16) < 12);

            bad = 1'b0;
            if (hcount !== 9'(h) || vcount !== 9'(v)) begin pos_err++; bad = 1'b1; end
            if (hsync   !== exp_hs)  begin hs_err++;  bad = 1'b1; end
            if (vsync   !== exp_vs)  begin vs_err++;  bad = 1'b1; end
            if (blank   !== exp_bl)  begin bl_err++;  bad = 1'b1; end
            if (display !== exp_dp)  begin dp_err++;  bad = 1'b1; end
            if (irq     !== exp_irq) begin irq_err++; bad = 1'b1; end
            if (contend !== exp_con) begin con_err++; bad = 1'b1; end
            if (bad && first_bad == "none")
                first_bad = $sformatf("h=%0d v=%0d", h, v);

            // Measurements taken from the outputs alone.
            since_h0++;
            if (hcount == 9'd0) begin
                h0_seen++;
                if (since_h0 != line_len) line_bad++;
                since_h0 = 0;
            end
            if (hsync === 1'b1) begin
                hs_w++;
            end else if (hs_w > 0) begin
                hs_pulses++;
                if (hs_w < hs_wmin) hs_wmin = hs_w;
                if (hs_w > hs_wmax) hs_wmax = hs_w;
                hs_w = 0;
            end
            if (vsync === 1'b1 && hcount == 9'd0) vs_lines++;
            if (irq === 1'b1) begin
                if (irq_rise_h < 0) begin
                    irq_rise_h = int'(hcount);
                    irq_rise_v = int'(vcount);
                end
                irq_cnt++;
            end
            if (contend === 1'b1 && vcount == 9'd0 && hcount >= 9'd1 && hcount <= 9'd15) con_v0++;
            if (contend === 1'b1 && vcount == 9'd200) con_v200++;

            // Change the model input mid-frame; it must not take effect yet.
            if (toggle_v >= 0 && v == toggle_v && h == 0) model = ~model;

            // Occasional ce=0 cycle: nothing may move.
            if (n % 9973 == 0) begin
                snap = {hcount, vcount, hsync, vsync, blank, display, irq, contend};
                tick(1'b0);
                if ({hcount, vcount, hsync, vsync, blank, display, irq, contend} !== snap)
                    hold_err++;
            end
        end

        check($sformatf("%s position errors (first %s)", name, first_bad), 32'(pos_err), 32'd0);
        check({name, " hsync errors"},    32'(hs_err),   32'd0);
        check({name, " vsync errors"},    32'(vs_err),   32'd0);
        check({name, " blank errors"},    32'(bl_err),   32'd0);
        check({name, " display errors"},  32'(dp_err),   32'd0);
        check({name, " irq errors"},      32'(irq_err),  32'd0);
        check({name, " contend errors"},  32'(con_err),  32'd0);
        check({name, " ce=0 hold errors"}, 32'(hold_err), 32'd0);
        check({name, " bad line lengths"}, 32'(line_bad), 32'd0);
        check({name, " lines in frame"},  32'(h0_seen),  32'(frame_len));
        check({name, " hsync pulses"},    32'(hs_pulses), 32'(frame_len));
        check({name, " hsync min width"}, 32'(hs_wmin),  32'd32);
        check({name, " hsync max width"}, 32'(hs_wmax),  32'd32);
        check({name, " vsync lines"},     32'(vs_lines), 32'd4);
        check({name, " irq width"},       32'(irq_cnt),  32'd64);
        check({name, " irq rise h"},      32'(irq_rise_h), 32'(int_h));
        check({name, " irq rise v"},      32'(irq_rise_v), 32'd248);
        check({name, " contend v0 h1..15"}, 32'(con_v0), CON_ON ? 32'd11 : 32'd0);
        check({name, " contend v200"},    32'(con_v200), 32'd0);
        check({name, " wrap hcount"},     32'(hcount),   32'd0);
        check({name, " wrap vcount"},     32'(vcount),   32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b0;
        model = 1'b0;

        // Reset held three clocks with ce toggling.
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        check_reset_state("reset");

        // ce=0 after release: counters stay put.
        reset = 1'b0;
        tick(1'b0);
        tick(1'b0);
        check("idle hcount", 32'(hcount), 32'd0);
        check("idle vcount", 32'(vcount), 32'd0);

        // 48K frame; model input flips to 128K at line 100 but this frame keeps 448x312.
        walk_frame("48k", 448, 312, 0, 0, 100);

        // Latched at the wrap: the next frame is 456x311 with irq at column 4.
        walk_frame("128k", 456, 311, 4, 2, -1);

        // Mid-frame reset with ce low returns to the reset state at once.
        for (int i = 0; i < 50; i++) tick(1'b1);
        check("pre-reset hcount", 32'(hcount), 32'd50);
        reset = 1'b1;
        tick(1'b0);
        check_reset_state("mid reset");
        reset = 1'b0;

        // Model input still 1, but reset latched 48K: first line is 448 long.
        for (int i = 0; i < 447; i++) tick(1'b1);
        check("post-reset h447", 32'(hcount), 32'd447);
        check("post-reset v0",   32'(vcount), 32'd0);
        tick(1'b1);
        check("post-reset wrap hcount", 32'(hcount), 32'd0);
        check("post-reset wrap vcount", 32'(vcount), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
